// File: rtl/tlul_pkg.sv
// Minimal TL-UL type definitions shared by crossbar-side blocks.
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_UW  = 14;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic [TL_UW-1:0]  a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic [TL_UW-1:0]  d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

    localparam logic [TL_UW-1:0] TL_D_USER_DEFAULT = '0;

endpackage

// File: rtl/tlul_reg_resp_pkg.sv
// Shared definitions for the TL-UL register responder: FSM states, request check, timeout default.
package tlul_reg_resp_pkg;

    import tlul_pkg::*;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    localparam int MAX_WAIT_DEFAULT = 15;

    // A request is malformed if it is not a supported opcode, wider than a word,
    // not word aligned, or a full-word put without all byte lanes enabled.
    function automatic logic req_err(tl_a_op_e op, logic [TL_SZW-1:0] size,
                                     logic [1:0] addr_lo, logic [TL_DBW-1:0] mask);
        logic op_ok;
        op_ok = (op == PutFullData) || (op == PutPartialData) || (op == Get);
        return !op_ok || (size > 2'd2) || (addr_lo != 2'b00) ||
               ((op == PutFullData) && (mask != '1));
    endfunction

endpackage

// File: rtl/tlul_reg_timeout_cnt.sv
// Saturating busy-cycle counter; expired_o flags the busy cycle that reaches MaxWait.
module tlul_reg_timeout_cnt
    import tlul_reg_resp_pkg::*;
#(
    parameter int MaxWait = MAX_WAIT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CntW = ($clog2(MaxWait + 1) > 4) ? $clog2(MaxWait + 1) : 4;

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = inc_i && (cnt_q == CntW'(MaxWait - 1));

endmodule

// File: rtl/tlul_reg_responder.sv
// TL-UL device responder: one outstanding A-channel request turned into a register-bus access.
// Optional busy timeout enabled by defining TLUL_REG_TIMEOUT_EN.
module tlul_reg_responder
    import tlul_pkg::*;
    import tlul_reg_resp_pkg::*;
#(
    parameter int RegAw   = 8,
    parameter int RegDw   = 32,
    parameter int MaxWait = MAX_WAIT_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  tl_h2d_t            tl_i,
    output tl_d2h_t            tl_o,
    output logic               reg_re_o,
    output logic               reg_we_o,
    output logic [RegAw-1:0]   reg_addr_o,
    output logic [RegDw-1:0]   reg_wdata_o,
    output logic [RegDw/8-1:0] reg_be_o,
    input  logic [RegDw-1:0]   reg_rdata_i,
    input  logic               reg_error_i,
    input  logic               reg_busy_i
);

    state_e              state_q, state_d;
    tl_a_op_e            opcode_q, opcode_d;
    logic [TL_SZW-1:0]   size_q, size_d;
    logic [TL_AIW-1:0]   source_q, source_d;
    logic [RegAw-3:0]    word_q, word_d;
    logic [RegDw/8-1:0]  mask_q, mask_d;
    logic [RegDw-1:0]    wdata_q, wdata_d;
    logic                re_q, re_d;
    logic                we_q, we_d;
    logic                d_valid_q, d_valid_d;
    logic                d_error_q, d_error_d;
    logic [RegDw-1:0]    d_data_q, d_data_d;

    logic accept;
    logic proto_err;
    logic timeout_expired;

    assign accept    = (state_q == StIdle) && tl_i.a_valid;
    assign proto_err = req_err(tl_i.a_opcode, tl_i.a_size, tl_i.a_address[1:0], tl_i.a_mask);

`ifdef TLUL_REG_TIMEOUT_EN
    tlul_reg_timeout_cnt #(
        .MaxWait (MaxWait)
    ) u_timeout_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (accept),
        .inc_i     ((re_q || we_q) && reg_busy_i),
        .expired_o (timeout_expired)
    );
`else
    localparam int unused_max_wait = MaxWait;
    assign timeout_expired = 1'b0;
`endif

    // NOTE: every _d starts from its _q so no branch can leave a value unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        size_d    = size_q;
        source_d  = source_q;
        word_d    = word_q;
        mask_d    = mask_q;
        wdata_d   = wdata_q;
        re_d      = re_q;
        we_d      = we_q;
        d_valid_d = d_valid_q;
        d_error_d = d_error_q;
        d_data_d  = d_data_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    opcode_d  = tl_i.a_opcode;
                    size_d    = tl_i.a_size;
                    source_d  = tl_i.a_source;
                    word_d    = tl_i.a_address[RegAw-1:2];
                    mask_d    = tl_i.a_mask;
                    wdata_d   = tl_i.a_data;
                    d_data_d  = '0;
                    d_error_d = 1'b0;
                    if (proto_err) begin
                        state_d   = StResp;
                        d_valid_d = 1'b1;
                        d_error_d = 1'b1;
                    end else begin
                        state_d = StAccess;
                        re_d    = (tl_i.a_opcode == Get);
                        we_d    = (tl_i.a_opcode != Get);
                    end
                end
            end
            StAccess: begin
                if (!reg_busy_i) begin
                    state_d   = StResp;
                    re_d      = 1'b0;
                    we_d      = 1'b0;
                    d_valid_d = 1'b1;
                    d_error_d = reg_error_i;
                    d_data_d  = (re_q && !reg_error_i) ? reg_rdata_i : '0;
                end else if (timeout_expired) begin
                    state_d   = StResp;
                    re_d      = 1'b0;
                    we_d      = 1'b0;
                    d_valid_d = 1'b1;
                    d_error_d = 1'b1;
                    d_data_d  = '0;
                end
            end
            StResp: begin
                if (tl_i.d_ready) begin
                    state_d   = StIdle;
                    d_valid_d = 1'b0;
                    d_error_d = 1'b0;
                    d_data_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only; all next-state logic lives above.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            opcode_q  <= PutFullData;
            size_q    <= '0;
            source_q  <= '0;
            word_q    <= '0;
            mask_q    <= '0;
            wdata_q   <= '0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            d_valid_q <= 1'b0;
            d_error_q <= 1'b0;
            d_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            size_q    <= size_d;
            source_q  <= source_d;
            word_q    <= word_d;
            mask_q    <= mask_d;
            wdata_q   <= wdata_d;
            re_q      <= re_d;
            we_q      <= we_d;
            d_valid_q <= d_valid_d;
            d_error_q <= d_error_d;
            d_data_q  <= d_data_d;
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = d_valid_q;
        tl_o.d_opcode = (opcode_q == Get) ? AccessAckData : AccessAck;
        tl_o.d_param  = '0;
        tl_o.d_size   = size_q;
        tl_o.d_source = source_q;
        tl_o.d_sink   = '0;
        tl_o.d_data   = d_data_q;
        tl_o.d_user   = TL_D_USER_DEFAULT;
        tl_o.d_error  = d_error_q;
        tl_o.a_ready  = (state_q == StIdle);
    end

    assign reg_re_o    = re_q;
    assign reg_we_o    = we_q;
    assign reg_addr_o  = {word_q, 2'b00};
    assign reg_wdata_o = wdata_q;
    assign reg_be_o    = mask_q;

    // Request fields a register device has no use for.
    logic unused_tl;
    assign unused_tl = ^{tl_i.a_param, tl_i.a_user, tl_i.a_address[TL_AW-1:RegAw]};

endmodule

// File: tb/tb_tlul_reg_responder.sv
// Scoreboard bench for tlul_reg_responder: random and directed requests against a transaction model.
module tb_tlul_reg_responder;
    import tlul_pkg::*;

    localparam int MaxWait = 15;

    typedef struct {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic [7:0]  source;
        logic        err;
        logic [31:0] data;
        int          accept_cyc;
        int          lat;
    } rsp_t;

    typedef struct {
        bit          we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          busy;
        logic [31:0] rdata;
        bit          err;
        bit          tmo;
        bit          aborted;
        int          accept_cyc;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    tl_h2d_t     a_req;
    logic        d_rdy;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic        reg_re_o, reg_we_o;
    logic [7:0]  reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic [3:0]  reg_be_o;
    logic [31:0] reg_rdata_i;
    logic        reg_error_i, reg_busy_i;

    rsp_t rsp_q[$];
    acc_t acc_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   ready_mode = 0;
    int   last_hs = -100;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        tl_i         = a_req;
        tl_i.d_ready = d_rdy;
    end

    tlul_reg_responder #(
        .RegAw   (8),
        .RegDw   (32),
        .MaxWait (MaxWait)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .tl_i        (tl_i),
        .tl_o        (tl_o),
        .reg_re_o    (reg_re_o),
        .reg_we_o    (reg_we_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_be_o    (reg_be_o),
        .reg_rdata_i (reg_rdata_i),
        .reg_error_i (reg_error_i),
        .reg_busy_i  (reg_busy_i)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one request (called on a falling edge) and record what the spec says must follow.
    task automatic issue(input logic [2:0] op, input logic [1:0] size, input logic [7:0] src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                         input int busy, input logic [31:0] rdata, input bit derr,
                         input bit aborted, input bit chk_b2b);
        bit   perr;
        bit   tmo;
        int   budget;
        rsp_t r;
        acc_t a;
        perr = !(op == 3'd0 || op == 3'd1 || op == 3'd4) || (size == 2'd3) ||
               (addr % 4 != 0) || (op == 3'd0 && mask != 4'hF);
        tmo = 1'b0;
`ifdef TLUL_REG_TIMEOUT_EN
        tmo = !perr && (busy >= MaxWait);
`endif
        a_req.a_valid   = 1'b1;
        a_req.a_opcode  = tl_a_op_e'(op);
        a_req.a_param   = 3'($urandom);
        a_req.a_size    = size;
        a_req.a_source  = src;
        a_req.a_address = addr;
        a_req.a_mask    = mask;
        a_req.a_data    = data;
        a_req.a_user    = 14'($urandom);
        budget = 0;
        while (!tl_o.a_ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (!tl_o.a_ready) begin
            check("accept_wait_budget", budget, 0);
            a_req.a_valid = 1'b0;
            return;
        end
        if (chk_b2b) check("b2b_accept_gap", cyc - last_hs, 1);
        r.opcode     = (op == 3'd4) ? 3'd1 : 3'd0;
        r.size       = size;
        r.source     = src;
        r.err        = perr || tmo || derr;
        r.data       = (op == 3'd4 && !r.err) ? rdata : 32'd0;
        r.accept_cyc = cyc;
        r.lat        = perr ? 1 : (tmo ? MaxWait + 1 : 2 + busy);
        if (!aborted) rsp_q.push_back(r);
        if (!perr) begin
            a.we         = (op != 3'd4);
            a.addr       = addr[7:0] & 8'hFC;
            a.wdata      = data;
            a.be         = mask;
            a.busy       = busy;
            a.rdata      = rdata;
            a.err        = derr;
            a.tmo        = tmo;
            a.aborted    = aborted;
            a.accept_cyc = cyc;
            acc_q.push_back(a);
        end
        @(negedge clk);
        a_req.a_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((rsp_q.size() != 0 || acc_q.size() != 0 || !tl_o.a_ready) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("drain_pending", rsp_q.size() + acc_q.size(), 0);
    endtask

    // Register device model and strobe monitor.
    initial begin
        acc_t cur;
        int   scnt;
        bit   active, done;
        logic s;
        scnt = 0;
        active = 1'b0;
        done = 1'b0;
        cur = '{default: '0};
        reg_busy_i = 1'b0;
        reg_rdata_i = '0;
        reg_error_i = 1'b0;
        forever begin
            @(negedge clk);
            s = reg_re_o | reg_we_o;
            if (active && done) begin
                check("strobe_released", s, 0);
                active = 1'b0;
                done = 1'b0;
                reg_busy_i = 1'b0;
            end else if (active && !s) begin
                check("strobe_drop_allowed", cur.tmo | cur.aborted, 1);
                if (cur.tmo && !cur.aborted) check("timeout_strobe_len", scnt, MaxWait);
                active = 1'b0;
                reg_busy_i = 1'b0;
            end else if (s) begin
                if (!active) begin
                    check("access_expected", acc_q.size() != 0, 1);
                    if (acc_q.size() != 0) cur = acc_q.pop_front();
                    else cur = '{default: '0};
                    active = 1'b1;
                    scnt = 0;
                    check("strobe_start_lat", cyc - cur.accept_cyc, 1);
                end
                reg_busy_i  = (scnt < cur.busy);
                reg_rdata_i = reg_busy_i ? ~cur.rdata : cur.rdata;
                reg_error_i = reg_busy_i ? ~cur.err : cur.err;
                scnt++;
                if (!reg_busy_i) begin
                    done = 1'b1;
                    check("strobe_kind", {reg_we_o, reg_re_o}, cur.we ? 2'b10 : 2'b01);
                    check("reg_addr", reg_addr_o, cur.addr);
                    if (cur.we) begin
                        check("reg_wdata", reg_wdata_o, cur.wdata);
                        check("reg_be", reg_be_o, cur.be);
                    end
                end
            end else begin
                reg_busy_i  = 1'b0;
                reg_rdata_i = $urandom;
                reg_error_i = 1'($urandom);
            end
        end
    end

    // D-channel monitor: drives d_ready, checks stability and pops the scoreboard on handshake.
    initial begin
        int      vcnt;
        int      first;
        bit      seen;
        tl_d2h_t snap;
        rsp_t    e;
        vcnt = 0;
        first = 0;
        seen = 1'b0;
        snap = '0;
        d_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                seen = 1'b0;
                d_rdy = 1'b1;
            end else if (tl_o.d_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    vcnt = 0;
                    snap = tl_o;
                    first = cyc;
                end else begin
                    check("stable_data", tl_o.d_data, snap.d_data);
                    check("stable_hdr", {tl_o.d_opcode, tl_o.d_size, tl_o.d_source, tl_o.d_error},
                          {snap.d_opcode, snap.d_size, snap.d_source, snap.d_error});
                end
                check("a_ready_in_resp", tl_o.a_ready, 0);
                case (ready_mode)
                    0:       d_rdy = 1'b1;
                    1:       d_rdy = ($urandom % 3 != 0);
                    default: d_rdy = (vcnt >= 5);
                endcase
                vcnt++;
                if (d_rdy) begin
                    check("rsp_expected", rsp_q.size() != 0, 1);
                    if (rsp_q.size() != 0) begin
                        e = rsp_q.pop_front();
                        check("d_opcode", tl_o.d_opcode, e.opcode);
                        check("d_size", tl_o.d_size, e.size);
                        check("d_source", tl_o.d_source, e.source);
                        check("d_error", tl_o.d_error, e.err);
                        check("d_data", tl_o.d_data, e.data);
                        check("d_latency", first - e.accept_cyc, e.lat);
                        check("d_param_sink_user", {tl_o.d_param, tl_o.d_sink, tl_o.d_user}, 0);
                    end
                    last_hs = cyc;
                    seen = 1'b0;
                end
            end else begin
                seen = 1'b0;
                d_rdy = (ready_mode == 1) ? 1'($urandom) : 1'b1;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  mask;
        int          sel;
        a_req = '0;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_d_valid", tl_o.d_valid, 0);
        check("rst_strobes", {reg_re_o, reg_we_o}, 0);
        check("rst_d_error", tl_o.d_error, 0);
        check("rst_d_data", tl_o.d_data, 0);
        check("rst_a_ready", tl_o.a_ready, 1);
        check("rst_reg_bus", {reg_addr_o, reg_wdata_o, reg_be_o}, 0);
        rst_ni = 1'b1;
        @(negedge clk);
        check("idle_a_ready", tl_o.a_ready, 1);

        // Zero-wait read and partial write.
        issue(3'd4, 2'd2, 8'h5A, 32'h0000_0008, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        drain();
        issue(3'd1, 2'd2, 8'h11, 32'h0000_0004, 4'b0011, 32'h0000_1234, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        drain();
        // Protocol errors: misaligned Get, unsupported opcode.
        issue(3'd4, 2'd2, 8'h12, 32'h0000_0006, 4'hF, 32'h0, 0, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        drain();
        issue(3'd3, 2'd2, 8'h13, 32'h0000_0010, 4'hF, 32'h0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        drain();
        // Busy for three cycles, then a device error.
        issue(3'd0, 2'd2, 8'h14, 32'h0000_0020, 4'hF, 32'h0BAD_F00D, 3, 32'h0, 1'b1, 1'b0, 1'b0);
        drain();
        // Held response plus a waiting second request.
        ready_mode = 2;
        issue(3'd4, 2'd2, 8'h21, 32'h0000_000C, 4'hF, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
        issue(3'd0, 2'd2, 8'h22, 32'h0000_0010, 4'hF, 32'hA5A5_A5A5, 0, 32'h0, 1'b0, 1'b0, 1'b1);
        drain();
        ready_mode = 0;
`ifdef TLUL_REG_TIMEOUT_EN
        issue(3'd4, 2'd2, 8'h31, 32'h0000_002C, 4'hF, 32'h0, 1000, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
`else
        issue(3'd4, 2'd2, 8'h31, 32'h0000_002C, 4'hF, 32'h0, 20, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
`endif
        drain();
        // Reset while the access is stalled.
        issue(3'd4, 2'd2, 8'h33, 32'h0000_0018, 4'hF, 32'h0, 1000, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check("midrst_strobes", {reg_re_o, reg_we_o}, 0);
        check("midrst_d_valid", tl_o.d_valid, 0);
        check("midrst_a_ready", tl_o.a_ready, 1);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (6) @(negedge clk);
        check("postrst_no_rsp", tl_o.d_valid, 0);
        drain();

        // Randomised traffic with a random d_ready pattern.
        ready_mode = 1;
        for (int n = 0; n < 150; n++) begin
            sel = $urandom % 10;
            op = (sel < 4) ? 3'd4 : (sel < 7) ? 3'd1 : (sel < 9) ? 3'd0 : 3'($urandom);
            size = ($urandom % 10 == 0) ? 2'($urandom) : 2'd2;
            addr = $urandom;
            if ($urandom % 8 != 0) addr[1:0] = 2'b00;
            mask = (op == 3'd0 && $urandom % 5 != 0) ? 4'hF : 4'($urandom);
            issue(op, size, 8'($urandom), addr, mask, $urandom, $urandom_range(0, 3),
                  $urandom, ($urandom % 8 == 0), 1'b0, 1'b0);
            repeat ($urandom % 3) @(negedge clk);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
